hex_guess_solver: RTL and testbench
===================================

Name: hex_guess_solver

Overview:
- Automatic codebreaker for the 4-digit hex guessing game; it is the initiator side of the guess/feedback exchange.
- Issues 16-bit guesses and consumes (correct_digits, wrong_place_digits) feedback from the checker.
- Deterministic search: find a filler digit absent from the secret, then solve each digit position in turn, then confirm the full solution.
- Feedback semantics are those of the team's checker: wrong_place never counts digit 0.

Parameters:
MAX_GUESSES, 72, guess budget; solver enters FAIL when guess_count reaches it unsolved (worst legal case needs 66).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a solve; ignored while busy
guess  output  16  current guess; digit p = guess[4p+:4]
guess_valid  output  1  guess presented, held until handshake
fb_valid  input  1  feedback valid; handshake = guess_valid && fb_valid on a rising edge
fb_correct  input  4  correct-position count for the current guess
fb_wrong  input  4  wrong-place count for the current guess
busy  output  1  solve in progress
done  output  1  solved; sticky until next start
fail  output  1  inconsistent feedback or budget exhausted; sticky until next start
solution  output  16  solved secret, valid when done
guess_count  output  7  handshakes completed in the current solve

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, absent mask 0, position 0, v 0. Reset mid-solve aborts immediately with no partial result.
- States: IDLE, FILL, POS, FINAL, DONE, FAIL. Each guessing state presents its guess with guess_valid=1 and waits for the handshake.
- Guess and guess_valid stay stable until the handshake. guess_valid deasserts the cycle after the handshake and stays low for at least 1 cycle before the next guess. Feedback is sampled only on the handshake edge.
- start in IDLE/DONE/FAIL: clear done, fail, guess_count, absent mask, solution; set v=0 and p=0; go to FILL. busy=1 from the next cycle until DONE/FAIL is entered.
- guess_count increments on every handshake, saturating at 127. If guess_count equals MAX_GUESSES after a handshake and the state is not DONE, go to FAIL (this check takes priority).
- FILL: guess = {4{v}}.
  - fb_correct==0: filler f=v, mark v absent, go to POS with v=0.
  - Otherwise v++. If v would pass F, go to FAIL.
- POS at position p: skip any v that is marked absent or equals f (the skip takes 0 cycles of handshake, at most 1 cycle per value). guess = f in every digit except v at digit p.
  - fb_correct==1: solution[4p+:4]=v. If p==3, go to FINAL; otherwise p++ and v=0.
  - fb_correct==0: if fb_wrong==0 and v!=0, mark v absent. Then v++; if v passes F, go to FAIL.
  - fb_correct>1: go to FAIL.
- FINAL: guess = solution. fb_correct==4 → DONE (done=1); otherwise → FAIL (fail=1).
- DONE/FAIL: guess_valid=0; guess holds its last value; busy=0.
- start asserted on the handshake cycle, or while busy, has no effect.

Test Plan:
- Secret 0x1234, checker responds with fb_valid the same cycle → filler 0 after 1 guess; guesses 0x0001, 0x0002, 0x0003, 0x0004, …; done=1, solution=0x1234, guess_count=12, fail=0.
- Secret 0x0000 → guesses 0x0000, then 0x1111 (filler 1); per-position guesses 0x1110, 0x1101, 0x1011, 0x0111; final guess 0x0000; done=1, guess_count=7.
- Secret 0xFFFF → values 1–E are marked absent during position 0; positions 1–3 each take 1 guess; done=1, solution=0xFFFF, guess_count=20.
- Feedback always (0,0) → filler 0, then position 0 sweeps 1..F with no hit → fail=1, done=0, guess_count=16, busy=0.
- Secret 0xA5C3 with fb_valid delayed 0–4 random cycles → guess is stable while valid; no double-count; guess_valid has ≥1 low cycle between guesses; done=1, solution=0xA5C3.
- rst_n pulsed low mid-POS → outputs are 0 asynchronously; a subsequent start solves 0x1234 again with guess_count=12; start asserted while busy is ignored.

Source files
------------

// File: rtl/hex_guess_solver.sv
// Automatic codebreaker for the 4-digit hex guessing game.
// Finds a filler digit absent from the secret, solves each digit position in turn, then confirms.
module hex_guess_solver #(
    parameter int MAX_GUESSES = 72
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [15:0] guess,
    output logic        guess_valid,
    input  logic        fb_valid,
    input  logic [3:0]  fb_correct,
    input  logic [3:0]  fb_wrong,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [15:0] solution,
    output logic [6:0]  guess_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_POS,
        S_FINAL,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [6:0] MAX_CNT = 7'(MAX_GUESSES);

    state_t      state_reg, state_next;
    logic [3:0]  v_reg, v_next;
    logic [1:0]  p_reg, p_next;
    logic [3:0]  f_reg, f_next;
    logic [15:0] absent_reg, absent_next;
    logic [15:0] solution_reg, solution_next;
    logic [6:0]  count_reg, count_next;
    logic [15:0] guess_reg, guess_next;
    logic        valid_reg, valid_next;

    logic        hs;
    logic [6:0]  count_inc;
    logic [15:0] pos_guess;

    assign hs        = valid_reg && fb_valid;
    assign count_inc = (count_reg == 7'd127) ? count_reg : count_reg + 7'd1;

    // Probe guess: filler everywhere except the candidate value at the position being solved.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pos_digit
            assign pos_guess[4*gi +: 4] = (p_reg == 2'(gi)) ? v_reg : f_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            v_reg        <= 4'd0;
            p_reg        <= 2'd0;
            f_reg        <= 4'd0;
            absent_reg   <= 16'd0;
            solution_reg <= 16'd0;
            count_reg    <= 7'd0;
            guess_reg    <= 16'd0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            v_reg        <= v_next;
            p_reg        <= p_next;
            f_reg        <= f_next;
            absent_reg   <= absent_next;
            solution_reg <= solution_next;
            count_reg    <= count_next;
            guess_reg    <= guess_next;
            valid_reg    <= valid_next;
        end
    end

    // A guessing state alternates between a prepare cycle (valid low) and a present phase (valid high).
    always_comb begin
        state_next    = state_reg;
        v_next        = v_reg;
        p_next        = p_reg;
        f_next        = f_reg;
        absent_next   = absent_reg;
        solution_next = solution_reg;
        count_next    = count_reg;
        guess_next    = guess_reg;
        valid_next    = valid_reg;

        case (state_reg)
            S_IDLE, S_DONE, S_FAIL: begin
                valid_next = 1'b0;
                if (start) begin
                    state_next    = S_FILL;
                    v_next        = 4'd0;
                    p_next        = 2'd0;
                    f_next        = 4'd0;
                    absent_next   = 16'd0;
                    solution_next = 16'd0;
                    count_next    = 7'd0;
                end
            end

            S_FILL: begin
                if (!valid_reg) begin
                    guess_next = {4{v_reg}};
                    valid_next = 1'b1;
                end else if (hs) begin
                    valid_next = 1'b0;
                    count_next = count_inc;
                    if (fb_correct == 4'd0) begin
                        f_next              = v_reg;
                        absent_next[v_reg]  = 1'b1;
                        v_next              = 4'd0;
                        state_next          = S_POS;
                    end else if (v_reg == 4'hF) begin
                        state_next = S_FAIL;
                    end else begin
                        v_next = v_reg + 4'd1;
                    end
                end
            end

            S_POS: begin
                if (!valid_reg) begin
                    if (absent_reg[v_reg] || v_reg == f_reg) begin
                        if (v_reg == 4'hF) state_next = S_FAIL;
                        else               v_next     = v_reg + 4'd1;
                    end else begin
                        guess_next = pos_guess;
                        valid_next = 1'b1;
                    end
                end else if (hs) begin
                    valid_next = 1'b0;
                    count_next = count_inc;
                    if (fb_correct == 4'd1) begin
                        solution_next[4*p_reg +: 4] = v_reg;
                        if (p_reg == 2'd3) begin
                            state_next = S_FINAL;
                        end else begin
                            p_next = p_reg + 2'd1;
                            v_next = 4'd0;
                        end
                    end else if (fb_correct == 4'd0) begin
                        // Digit 0 never shows up as wrong-place, so its absence cannot be inferred.
                        if (fb_wrong == 4'd0 && v_reg != 4'd0)
                            absent_next[v_reg] = 1'b1;
                        if (v_reg == 4'hF) state_next = S_FAIL;
                        else               v_next     = v_reg + 4'd1;
                    end else begin
                        state_next = S_FAIL;
                    end
                end
            end

            S_FINAL: begin
                if (!valid_reg) begin
                    guess_next = solution_reg;
                    valid_next = 1'b1;
                end else if (hs) begin
                    valid_next = 1'b0;
                    count_next = count_inc;
                    state_next = (fb_correct == 4'd4) ? S_DONE : S_FAIL;
                end
            end

            default: begin
                state_next = S_IDLE;
                valid_next = 1'b0;
            end
        endcase

        if (hs && count_inc == MAX_CNT && state_next != S_DONE)
            state_next = S_FAIL;
    end

    always_comb begin
        busy        = (state_reg == S_FILL) || (state_reg == S_POS) || (state_reg == S_FINAL);
        done        = (state_reg == S_DONE);
        fail        = (state_reg == S_FAIL);
        guess       = guess_reg;
        guess_valid = valid_reg;
        solution    = solution_reg;
        guess_count = count_reg;
    end

endmodule

// File: tb/tb_hex_guess_solver.sv
// Self-checking bench for hex_guess_solver: a checker model answers guesses, table vectors plus reset/handshake sequences.
module tb_hex_guess_solver;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] guess;
    logic        guess_valid;
    logic        fb_valid;
    logic [3:0]  fb_correct;
    logic [3:0]  fb_wrong;
    logic        busy;
    logic        done;
    logic        fail;
    logic [15:0] solution;
    logic [6:0]  guess_count;

    hex_guess_solver #(.MAX_GUESSES(72)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .guess       (guess),
        .guess_valid (guess_valid),
        .fb_valid    (fb_valid),
        .fb_correct  (fb_correct),
        .fb_wrong    (fb_wrong),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .solution    (solution),
        .guess_count (guess_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] resp_secret = 16'h0000;
    int          resp_dmax   = 0;
    bit          resp_zero   = 1'b0;
    bit          resp_en     = 1'b0;
    int          hs_cnt      = 0;
    logic [15:0] log_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Checker model: wrong-place counts only digits 1..F.
    function automatic void calc_fb(input logic [15:0] g, input logic [15:0] s,
                                    output logic [3:0] c, output logic [3:0] w);
        int gc[16];
        int sc[16];
        logic [3:0] gd, sd;
        c = 4'd0;
        w = 4'd0;
        for (int i = 0; i < 16; i++) begin
            gc[i] = 0;
            sc[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            gd = g[4*i +: 4];
            sd = s[4*i +: 4];
            if (gd == sd) begin
                c = c + 4'd1;
            end else begin
                gc[gd]++;
                sc[sd]++;
            end
        end
        for (int d = 1; d < 16; d++)
            w = w + 4'((gc[d] < sc[d]) ? gc[d] : sc[d]);
    endfunction

    // Responder: waits a random delay, answers, and checks stability and the low gap after each handshake.
    initial begin : responder
        logic [15:0] g;
        int          d;
        logic [3:0]  c, w;
        fb_valid   = 1'b0;
        fb_correct = 4'd0;
        fb_wrong   = 4'd0;
        forever begin
            @(negedge clk);
            if (resp_en && rst_n && guess_valid) begin
                g = guess;
                d = int'($urandom_range(0, resp_dmax));
                for (int k = 0; k < d; k++) begin
                    @(negedge clk);
                    chk("guess_stable", guess, g);
                    chk("valid_held", guess_valid, 1);
                end
                if (resp_zero) begin
                    c = 4'd0;
                    w = 4'd0;
                end else begin
                    calc_fb(g, resp_secret, c, w);
                end
                fb_correct = c;
                fb_wrong   = w;
                fb_valid   = 1'b1;
                @(negedge clk);
                fb_valid = 1'b0;
                hs_cnt++;
                log_q.push_back(g);
                chk("valid_gap", guess_valid, 0);
            end
        end
    end

    task automatic run_solve(input logic [15:0] sec, input int dmax, input bit zero, input bit poke);
        bit finished;
        resp_secret = sec;
        resp_dmax   = dmax;
        resp_zero   = zero;
        hs_cnt      = 0;
        log_q.delete();
        resp_en     = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        finished = 1'b0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            @(negedge clk);
            start = (poke && c == 10) ? 1'b1 : 1'b0;
            if (done || fail) finished = 1'b1;
        end
        start = 1'b0;
        chk("solve_timeout", finished, 1);
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] secret;
        int          dmax;
        bit          zero_mode;
        bit          exp_done;
        bit          exp_fail;
        int          exp_count;
        logic [15:0] exp_sol;
    } vec_t;

    vec_t vecs[6];

    logic [15:0] seq1[5];
    logic [15:0] seq2[7];

    initial begin
        vecs[0] = '{16'h1234, 0, 1'b0, 1'b1, 1'b0, 12, 16'h1234};
        vecs[1] = '{16'h0000, 0, 1'b0, 1'b1, 1'b0,  7, 16'h0000};
        vecs[2] = '{16'hFFFF, 0, 1'b0, 1'b1, 1'b0, 20, 16'hFFFF};
        vecs[3] = '{16'h0000, 0, 1'b1, 1'b0, 1'b1, 16, 16'h0000};
        vecs[4] = '{16'hA5C3, 4, 1'b0, 1'b1, 1'b0, 20, 16'hA5C3};
        vecs[5] = '{16'h1234, 2, 1'b0, 1'b1, 1'b0, 12, 16'h1234};
        seq1 = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        seq2 = '{16'h0000, 16'h1111, 16'h1110, 16'h1101, 16'h1011, 16'h0111, 16'h0000};

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", guess_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_fail", fail, 0);
        chk("reset_guess", guess, 0);
        chk("reset_count", guess_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Guess sequences for the first two secrets.
        run_solve(16'h1234, 0, 1'b0, 1'b0);
        chk("seq1_len", log_q.size(), 12);
        for (int i = 0; i < 5; i++)
            if (i < log_q.size()) chk($sformatf("seq1_guess%0d", i), log_q[i], seq1[i]);
        run_solve(16'h0000, 0, 1'b0, 1'b0);
        chk("seq2_len", log_q.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < log_q.size()) chk($sformatf("seq2_guess%0d", i), log_q[i], seq2[i]);

        for (int i = 0; i < 6; i++) begin
            run_solve(vecs[i].secret, vecs[i].dmax, vecs[i].zero_mode, 1'b0);
            chk($sformatf("v%0d_done", i), done, vecs[i].exp_done);
            chk($sformatf("v%0d_fail", i), fail, vecs[i].exp_fail);
            chk($sformatf("v%0d_count", i), guess_count, vecs[i].exp_count);
            chk($sformatf("v%0d_handshakes", i), hs_cnt, vecs[i].exp_count);
            chk($sformatf("v%0d_solution", i), solution, vecs[i].exp_sol);
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_valid", i), guess_valid, 0);
            $display("vector %0d secret=%h done=%0d fail=%0d count=%0d solution=%h",
                     i, vecs[i].secret, done, fail, guess_count, solution);
        end

        // Reset mid-solve, then a clean solve with a stray start pulse while busy.
        resp_secret = 16'h1234;
        resp_dmax   = 0;
        resp_zero   = 1'b0;
        hs_cnt      = 0;
        resp_en     = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin : wait_pos
            bit reached;
            reached = 1'b0;
            for (int c = 0; c < 500 && !reached; c++) begin
                @(posedge clk);
                if (hs_cnt >= 3) reached = 1'b1;
            end
            chk("reach_pos_timeout", reached, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        resp_en = 1'b0;
        chk("arst_valid", guess_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_guess", guess, 0);
        chk("arst_count", guess_count, 0);
        chk("arst_solution", solution, 0);
        chk("arst_done_fail", {done, fail}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        run_solve(16'h1234, 0, 1'b0, 1'b1);
        chk("rerun_done", done, 1);
        chk("rerun_fail", fail, 0);
        chk("rerun_count", guess_count, 12);
        chk("rerun_solution", solution, 16'h1234);
        $display("rerun after reset: done=%0d count=%0d solution=%h", done, guess_count, solution);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
